// File: rtl/prog_feeder.sv
// Program RAM plus sequencer that plays instruction words into the CPU
// DIN/run/Done handshake, stopping on HALT word, end of memory or timeout.
module prog_feeder #(
  parameter int         DEPTH      = 32,
  parameter int         AW         = 5,
  parameter logic [2:0] IMM_OPCODE = 3'b001,
  parameter logic [8:0] HALT_WORD  = 9'h1FF,
  parameter int         TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [8:0]    wr_data,
  input  logic          Done,
  output logic [8:0]    DIN,
  output logic          run,
  output logic          busy,
  output logic          halted,
  output logic          error,
  output logic [AW-1:0] pc,
  output logic [7:0]    instr_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_HALT,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [8:0]    mem_q [DEPTH];
  logic [8:0]    cur_w;
  logic [8:0]    imm_w;
  logic [AW:0]   pc_step;
  logic          tmo_hit;

  assign cur_w   = mem_q[pc_q];
  assign imm_w   = mem_q[pc_q + AW'(1)];
  assign tmo_hit = (tmo_q + TW'(1)) == TW'(TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !busy) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    pc_step = {1'b0, pc_q}
            + ((state_q == S_IMM) ? (AW+1)'(2) : (AW+1)'(1));
    unique case (state_q)
      S_IDLE, S_HALT, S_ERR: begin
        if (start) begin
          state_d = S_ISSUE;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        // the issue cycle itself counts toward the Done budget
        tmo_d = TW'(1);
        if (cur_w == HALT_WORD) begin
          state_d = S_HALT;
        end else if (cur_w[8:6] == IMM_OPCODE) begin
          if (pc_q == AW'(DEPTH - 1)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_IMM;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_IMM, S_WAIT: begin
        if (Done) begin
          if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
          if (pc_step > (AW+1)'(DEPTH - 1)) begin
            state_d = S_HALT;
            pc_d    = AW'(DEPTH - 1);
          end else begin
            state_d = S_ISSUE;
            pc_d    = pc_step[AW-1:0];
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_hit) begin
            state_d = S_ERR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    DIN    = '0;
    run    = 1'b0;
    busy   = 1'b0;
    halted = 1'b0;
    error  = 1'b0;
    unique case (state_q)
      S_ISSUE: begin
        busy = 1'b1;
        if (cur_w != HALT_WORD) begin
          DIN = cur_w;
          run = 1'b1;
        end
      end
      S_IMM: begin
        busy = 1'b1;
        DIN  = imm_w;
      end
      S_WAIT:  busy   = 1'b1;
      S_HALT:  halted = 1'b1;
      S_ERR:   error  = 1'b1;
      default: ;
    endcase
  end

  assign pc          = pc_q;
  assign instr_count = cnt_q;

endmodule
